// File: rtl/force_release_pkg.sv
// Shared encodings for the force/release register: request opcodes,
// response status codes and the register's control states.
package force_release_pkg;

   // Request opcodes carried on req_op
   localparam logic [1:0] OP_FORCE    = 2'd0;
   localparam logic [1:0] OP_RELEASE  = 2'd1;
   localparam logic [1:0] OP_DEPOSIT  = 2'd2;
   localparam logic [1:0] OP_RESERVED = 2'd3;

   // Response codes carried on ack_status
   localparam logic [1:0] STATUS_OK             = 2'd0;
   localparam logic [1:0] STATUS_ERR_NOT_FORCED = 2'd1;
   localparam logic [1:0] STATUS_ERR_FORCED     = 2'd2;
   localparam logic [1:0] STATUS_ERR_BAD_OP     = 2'd3;

   // Control states: HOLD is "released but still showing the forced value"
   localparam logic [1:0] STATE_UNFORCED = 2'd0;
   localparam logic [1:0] STATE_FORCED   = 2'd1;
   localparam logic [1:0] STATE_HOLD     = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   // Count increment requests, holding once every bit is set
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/force_release_reg.sv
// Register whose functional d/en path can be overridden through a
// request/acknowledge control channel (force, release, deposit).
module force_release_reg
   import force_release_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_value,
   output logic             ack_valid,
   input  logic             ack_ready,
   output logic [1:0]       ack_status,
   output logic [WIDTH-1:0] q,
   output logic             forced,
   output logic [CNT_W-1:0] force_cnt
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [1:0]       status_nxt;
   logic             accept;
   logic             cnt_inc;

   // A new request may enter whenever the response slot is free or being drained
   always_comb begin
      req_ready = !rst && (!ack_valid || ack_ready);
      accept    = req_valid && req_ready;
   end

   // Next value of q/state; an accepted request owns the edge over the d/en path,
   // so an erroring request leaves everything untouched
   always_comb begin
      state_nxt  = state;
      q_nxt      = q;
      status_nxt = STATUS_OK;
      cnt_inc    = 1'b0;
      if (accept) begin
         case (req_op)
            OP_FORCE: begin
               q_nxt     = req_value;
               state_nxt = STATE_FORCED;
               cnt_inc   = 1'b1;
            end
            OP_RELEASE: begin
               if (state == STATE_FORCED) begin
                  state_nxt = STATE_HOLD;
               end else begin
                  status_nxt = STATUS_ERR_NOT_FORCED;
               end
            end
            OP_DEPOSIT: begin
               if (state == STATE_FORCED) begin
                  status_nxt = STATUS_ERR_FORCED;
               end else begin
                  q_nxt     = req_value;
                  state_nxt = STATE_UNFORCED;
               end
            end
            default: begin
               status_nxt = STATUS_ERR_BAD_OP;
            end
         endcase
      end else begin
         case (state)
            STATE_UNFORCED: begin
               if (en) begin
                  q_nxt = d;
               end
            end
            STATE_HOLD: begin
               if (en) begin
                  q_nxt     = d;
                  state_nxt = STATE_UNFORCED;
               end
            end
            default: begin
               q_nxt = q;
            end
         endcase
      end
   end

   // Register state, visible value and the forced flag together so they move on one edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= STATE_UNFORCED;
         q      <= '0;
         forced <= 1'b0;
      end else begin
         state  <= state_nxt;
         q      <= q_nxt;
         forced <= (state_nxt == STATE_FORCED);
      end
   end

   // Single response slot: filled on acceptance, held stable until consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_valid  <= 1'b0;
         ack_status <= STATUS_OK;
      end else if (accept) begin
         ack_valid  <= 1'b1;
         ack_status <= status_nxt;
      end else if (ack_ready) begin
         ack_valid  <= 1'b0;
      end
   end

   sat_counter #(
      .WIDTH(CNT_W)
   ) u_force_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (cnt_inc),
      .count(force_cnt)
   );

endmodule

// File: tb/tb_force_release_reg.sv
// Self-checking bench for force_release_reg: directed table, multi-cycle
// corner sequences and a randomized run against a behavioural model.
module tb_force_release_reg;

   localparam int WIDTH   = 4;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] d;
   logic             en;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [WIDTH-1:0] req_value;
   logic             ack_valid;
   logic             ack_ready;
   logic [1:0]       ack_status;
   logic [WIDTH-1:0] q;
   logic             forced;
   logic [CNT_W-1:0] force_cnt;

   force_release_reg #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .d         (d),
      .en        (en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_value (req_value),
      .ack_valid (ack_valid),
      .ack_ready (ack_ready),
      .ack_status(ack_status),
      .q         (q),
      .forced    (forced),
      .force_cnt (force_cnt)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vectors;
   int n_miscompares;

   // Reference model: mode 0 = normal, 1 = forced, 2 = released-but-holding
   int m_q;
   int m_mode;
   int m_cnt;
   int m_av;
   int m_st;

   typedef struct {
      logic       rst;
      logic [3:0] d;
      logic       en;
      logic       rv;
      logic [1:0] op;
      logic [3:0] val;
      logic       ar;
      logic [3:0] eq;
      logic       ef;
      logic       eav;
      logic [1:0] est;
      int         ecnt;
   } vec_t;

   vec_t tbl[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
      end
   endtask

   // Advance the model by one clock edge from the given inputs
   task automatic modelStep(input logic r, input logic [3:0] dv, input logic e, input logic rv,
                            input logic [1:0] op, input logic [3:0] val, input logic ar);
      bit ready;
      if (r) begin
         m_q = 0; m_mode = 0; m_cnt = 0; m_av = 0; m_st = 0;
         return;
      end
      ready = (m_av == 0) || ar;
      if (rv && ready) begin
         m_av = 1;
         if (op == 0) begin
            m_q = val; m_mode = 1; m_st = 0;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         end else if (op == 1) begin
            if (m_mode == 1) begin m_mode = 2; m_st = 0; end
            else m_st = 1;
         end else if (op == 2) begin
            if (m_mode == 1) m_st = 2;
            else begin m_q = val; m_mode = 0; m_st = 0; end
         end else begin
            m_st = 3;
         end
      end else begin
         if (ar) m_av = 0;
         if (m_mode != 1 && e) begin
            m_q = dv; m_mode = 0;
         end
      end
   endtask

   // Compare every visible output with the model after an edge
   task automatic checkModel();
      checkOutput("q", 32'(q), 32'(m_q));
      checkOutput("forced", 32'(forced), 32'(m_mode == 1));
      checkOutput("force_cnt", 32'(force_cnt), 32'(m_cnt));
      checkOutput("ack_valid", 32'(ack_valid), 32'(m_av));
      if (m_av != 0) checkOutput("ack_status", 32'(ack_status), 32'(m_st));
   endtask

   // Drive one cycle of inputs, check req_ready before the edge, outputs after it
   task automatic applyStimulus(input logic r, input logic [3:0] dv, input logic e, input logic rv,
                                input logic [1:0] op, input logic [3:0] val, input logic ar);
      rst = r; d = dv; en = e; req_valid = rv; req_op = op; req_value = val; ack_ready = ar;
      #1;
      checkOutput("req_ready", 32'(req_ready), 32'(!r && ((m_av == 0) || ar)));
      modelStep(r, dv, e, rv, op, val, ar);
      @(posedge clk);
      #1;
      checkModel();
   endtask

   function automatic vec_t mk(input logic r, input logic [3:0] dv, input logic e, input logic rv,
                               input logic [1:0] op, input logic [3:0] val, input logic ar,
                               input logic [3:0] eq, input logic ef, input logic eav,
                               input logic [1:0] est, input int ecnt);
      vec_t v;
      v.rst = r; v.d = dv; v.en = e; v.rv = rv; v.op = op; v.val = val; v.ar = ar;
      v.eq = eq; v.ef = ef; v.eav = eav; v.est = est; v.ecnt = ecnt;
      return v;
   endfunction

   initial begin
      logic [1:0] held_status;
      n_vectors = 0;
      n_miscompares = 0;
      m_q = 0; m_mode = 0; m_cnt = 0; m_av = 0; m_st = 0;
      rst = 1; d = 0; en = 0; req_valid = 0; req_op = 0; req_value = 0; ack_ready = 1;
      @(posedge clk);
      #1;

      // Directed table: rst, d, en, rv, op, val, ar | q, forced, ack_valid, status, cnt
      tbl.push_back(mk(1, 4'h0, 0, 0, 0, 4'h0, 1,  4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4'h0, 0, 0, 0, 4'h0, 1,  4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h1, 1, 0, 0, 4'h0, 1,  4'h1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h1, 1, 1, 0, 4'h0, 1,  4'h0, 1, 1, 0, 1));
      tbl.push_back(mk(0, 4'h1, 1, 0, 0, 4'h0, 1,  4'h0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h1, 1, 0, 0, 4'h0, 1,  4'h0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h1, 1, 0, 0, 4'h0, 1,  4'h0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h1, 1, 0, 0, 4'h0, 1,  4'h0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h1, 0, 1, 1, 4'h0, 1,  4'h0, 0, 1, 0, 1));
      tbl.push_back(mk(0, 4'h1, 0, 0, 0, 4'h0, 1,  4'h0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 4'h1, 0, 0, 0, 4'h0, 1,  4'h0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 4'h1, 1, 0, 0, 4'h0, 1,  4'h1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 4'h1, 0, 1, 1, 4'h0, 1,  4'h1, 0, 1, 1, 1));
      tbl.push_back(mk(0, 4'h1, 0, 1, 0, 4'h5, 1,  4'h5, 1, 1, 0, 2));
      tbl.push_back(mk(0, 4'h1, 0, 1, 2, 4'h9, 1,  4'h5, 1, 1, 2, 2));
      tbl.push_back(mk(0, 4'h1, 0, 1, 3, 4'h3, 1,  4'h5, 1, 1, 3, 2));
      tbl.push_back(mk(0, 4'h1, 0, 1, 1, 4'h0, 1,  4'h5, 0, 1, 0, 2));
      tbl.push_back(mk(0, 4'h1, 1, 1, 2, 4'hA, 1,  4'hA, 0, 1, 0, 2));
      tbl.push_back(mk(0, 4'h1, 0, 1, 0, 4'h7, 1,  4'h7, 1, 1, 0, 3));
      tbl.push_back(mk(0, 4'h1, 0, 1, 1, 4'h0, 1,  4'h7, 0, 1, 0, 3));
      tbl.push_back(mk(0, 4'h2, 1, 1, 3, 4'h0, 1,  4'h7, 0, 1, 3, 3));
      tbl.push_back(mk(0, 4'h2, 1, 0, 0, 4'h0, 1,  4'h2, 0, 0, 0, 3));
      tbl.push_back(mk(0, 4'h3, 1, 1, 2, 4'h6, 1,  4'h6, 0, 1, 0, 3));
      tbl.push_back(mk(0, 4'h3, 0, 0, 0, 4'h0, 1,  4'h6, 0, 0, 0, 3));

      foreach (tbl[i]) begin
         applyStimulus(tbl[i].rst, tbl[i].d, tbl[i].en, tbl[i].rv, tbl[i].op, tbl[i].val, tbl[i].ar);
         checkOutput("tbl_q", 32'(q), 32'(tbl[i].eq));
         checkOutput("tbl_forced", 32'(forced), 32'(tbl[i].ef));
         checkOutput("tbl_ack_valid", 32'(ack_valid), 32'(tbl[i].eav));
         if (tbl[i].eav) checkOutput("tbl_ack_status", 32'(ack_status), 32'(tbl[i].est));
         checkOutput("tbl_force_cnt", 32'(force_cnt), 32'(tbl[i].ecnt));
      end

      // Backpressure: ack held stable while ack_ready is low, new requests refused
      applyStimulus(0, 4'h0, 0, 1, 0, 4'hC, 0);
      held_status = ack_status;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 4'h1, 1, 1, 2, 4'h3, 0);
         checkOutput("bp_ack_valid", 32'(ack_valid), 32'd1);
         checkOutput("bp_status_stable", 32'(ack_status), 32'(held_status));
         checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
         checkOutput("bp_q", 32'(q), 32'hC);
      end
      applyStimulus(0, 4'h0, 0, 0, 0, 4'h0, 1);

      // Saturation: 300 back-to-back FORCEs
      for (int i = 0; i < 300; i++) begin
         applyStimulus(0, 4'h0, 0, 1, 0, 4'(i), 1);
      end
      checkOutput("sat_force_cnt", 32'(force_cnt), 32'(CNT_MAX));

      // Reset while forced with an unconsumed acknowledge
      applyStimulus(0, 4'h0, 0, 1, 0, 4'hF, 0);
      applyStimulus(1, 4'h0, 0, 1, 2, 4'h4, 0);
      checkOutput("rst_q", 32'(q), 32'd0);
      checkOutput("rst_forced", 32'(forced), 32'd0);
      checkOutput("rst_ack_valid", 32'(ack_valid), 32'd0);
      checkOutput("rst_force_cnt", 32'(force_cnt), 32'd0);
      applyStimulus(0, 4'h0, 0, 0, 0, 4'h0, 1);
      checkOutput("post_rst_ack_valid", 32'(ack_valid), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom_range(0, 49) == 0), 4'($urandom), 1'($urandom),
                       1'($urandom), 2'($urandom), 4'($urandom),
                       ($urandom_range(0, 9) < 7));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/force_release_reg.md
FORCE_RELEASE_REG -- requirements
Module: force_release_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning the data width of the register, forced value and deposit value.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the saturating force-event counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port d, input, WIDTH bits: functional next-state value of the register.
REQ-006 SHALL have port en, input, 1 bit: functional capture enable; d is captured when en=1.
REQ-007 SHALL have port req_valid, input, 1 bit: control request valid.
REQ-008 SHALL have port req_ready, output, 1 bit: control request accepted when req_valid and req_ready are both 1.
REQ-009 SHALL have port req_op, input, 2 bits: 0=FORCE, 1=RELEASE, 2=DEPOSIT, 3=reserved.
REQ-010 SHALL have port req_value, input, WIDTH bits: value for FORCE/DEPOSIT.
REQ-011 SHALL have port ack_valid, output, 1 bit: response valid.
REQ-012 SHALL have port ack_ready, input, 1 bit: response consumed when ack_valid and ack_ready are both 1.
REQ-013 SHALL have port ack_status, output, 2 bits: 0=OK, 1=ERR_NOT_FORCED, 2=ERR_FORCED, 3=ERR_BAD_OP.
REQ-014 SHALL have port q, output, WIDTH bits: visible register value.
REQ-015 SHALL have port forced, output, 1 bit: 1 while state is FORCED.
REQ-016 SHALL have port force_cnt, output, CNT_W bits: number of accepted FORCE ops, saturating.

Function
REQ-017 SHALL implement states UNFORCED, FORCED and HOLD (released, retaining forced value).
REQ-018 In UNFORCED, q SHALL load d on each edge with en=1 and hold otherwise.
REQ-019 An accepted FORCE SHALL update q to req_value on the same edge, enter FORCED and increment force_cnt, saturating at all-ones; FORCE while FORCED SHALL replace the value and report OK.
REQ-020 In FORCED, q SHALL ignore d/en and keep the forced value.
REQ-021 An accepted RELEASE in FORCED SHALL enter HOLD with q unchanged; a RELEASE in UNFORCED or HOLD SHALL report ERR_NOT_FORCED and change no state.
REQ-022 In HOLD, q SHALL keep the forced value until the first edge with en=1, then load d and enter UNFORCED (variable release semantics).
REQ-023 An accepted DEPOSIT in UNFORCED or HOLD SHALL load q with req_value and enter UNFORCED; if en=1 on the same edge, the deposit SHALL take priority for that edge.
REQ-024 A DEPOSIT in FORCED SHALL report ERR_FORCED and leave q unchanged; op 3 SHALL report ERR_BAD_OP and change no state.
REQ-025 An accepted request in HOLD together with en=1 on the same edge SHALL be resolved in favour of the request.
REQ-026 Each accepted request SHALL produce exactly one response: ack_valid is asserted on the cycle after acceptance and held with a stable ack_status until ack_ready=1.
REQ-027 Only one request SHALL be outstanding: req_ready = !ack_valid || ack_ready, so back-to-back requests sustain one request per cycle when ack_ready=1.
REQ-028 forced SHALL equal (state==FORCED), registered, and SHALL change on the same edge as q.

Reset
REQ-029 When rst=1 at an edge, the block SHALL set state=UNFORCED, q=0, forced=0, force_cnt=0 and ack_valid=0, and ack_status SHALL read 0.
REQ-030 While rst=1, req_ready SHALL be 0.
REQ-031 Reset SHALL override any in-flight request or pending acknowledge, with no response issued.

Structure
REQ-032 The op encodings, status encodings and state enum SHALL reside in package force_release_pkg.
REQ-033 The saturating counter SHALL be a separate sub-module, sat_counter, parameterised by width.

Verification
REQ-034 Baseline: rst for 2 cycles, then d=1, en=1 -> q=1 one edge later; forced=0; force_cnt=0.
REQ-035 Force: FORCE value 0 while d=1, en=1 -> q=0 on the accept edge, forced=1, ack OK next cycle, q stays 0 for 4 cycles, force_cnt=1.
REQ-036 Release: RELEASE with en=0 for 3 cycles -> q stays 0, forced=0; en=1 with d=1 -> q=1 on that edge.
REQ-037 Errors: RELEASE while UNFORCED -> ERR_NOT_FORCED; DEPOSIT while FORCED -> ERR_FORCED; op 3 -> ERR_BAD_OP; q unchanged in all three cases.
REQ-038 Backpressure: ack_ready=0 for 5 cycles -> ack_valid held with stable status and req_ready=0; 300 FORCEs -> force_cnt=255 with CNT_W=8.
REQ-039 Reset mid-op: assert rst while FORCED with an ack pending -> next cycle q=0, forced=0, ack_valid=0.
